// File: rtl/sysid_timer_regs_if.sv
// Avalon-MM slave bus bundle for the system-ID / timer register block.
//   address       word address (3 bits)
//   chipselect    slave select
//   read, write   strobes, qualified by chipselect
//   writedata     32-bit write data
//   byteenable    write byte lanes
//   readdata      registered read data
//   readdatavalid one-cycle pulse marking valid read data
interface sysid_timer_regs_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;
   logic        readdatavalid;

   modport master (
      output address, chipselect, read, write, writedata, byteenable,
      input  readdata, readdatavalid
   );

   modport slave (
      input  address, chipselect, read, write, writedata, byteenable,
      output readdata, readdatavalid
   );
endinterface

// File: rtl/sysid_timer_regs.sv
// System-ID slave with free-running time counters.
// Returns fixed ID/timestamp/capability words, a 64-bit cycle counter read
// coherently as LO then HI, a millisecond counter, and a byte-writable
// scratch register. Read latency is fixed at one cycle.
// Ports:
//   clock     system clock
//   reset_n   asynchronous active-low reset; release is expected to be
//             synchronous to clock
//   bus       Avalon-MM slave (sysid_timer_regs_if.slave)
//   heartbeat ms_count[HB_BIT]
module sysid_timer_regs #(
   parameter logic [31:0] ID_VALUE     = 32'h59E6_1DEB,
   parameter logic [31:0] TIMESTAMP    = 32'h0,
   parameter int unsigned TICK_DIV     = 50000,
   parameter logic [31:0] SCRATCH_INIT = 32'h0,
   parameter int unsigned HB_BIT       = 9,
   parameter logic [15:0] VERSION      = 16'h0002
) (
   input  logic                  clock,
   input  logic                  reset_n,
   sysid_timer_regs_if.slave     bus,
   output logic                  heartbeat
);

   typedef enum logic [2:0] {
      REG_ID      = 3'd0,
      REG_TSTAMP  = 3'd1,
      REG_CYC_LO  = 3'd2,
      REG_CYC_HI  = 3'd3,
      REG_MS      = 3'd4,
      REG_SCRATCH = 3'd5,
      REG_CAPS    = 3'd6,
      REG_CTRL    = 3'd7
   } reg_addr_e;

   localparam int unsigned    PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

   logic [63:0]   cyc_cnt;
   logic [31:0]   cyc_snap_hi;
   logic [PW-1:0] presc;
   logic [31:0]   ms_count;
   logic [31:0]   scratch;
   logic [31:0]   rd_mux;
   logic          rd;
   logic          wr;
   logic          clr;
   reg_addr_e     addr;

   // A read in the same cycle as a write wins; the write is dropped.
   // This also keeps a CTRL clear from ever coinciding with a CYC_LO read.
   always_comb begin
      addr = reg_addr_e'(bus.address);
      rd   = bus.chipselect & bus.read;
      wr   = bus.chipselect & bus.write & ~bus.read;
      clr  = wr && (addr == REG_CTRL) && bus.writedata[0];
      heartbeat = ms_count[HB_BIT];
   end

   always_comb begin
      rd_mux = '0;
      case (addr)
         REG_ID:      rd_mux = ID_VALUE;
         REG_TSTAMP:  rd_mux = TIMESTAMP;
         REG_CYC_LO:  rd_mux = cyc_cnt[31:0];
         REG_CYC_HI:  rd_mux = cyc_snap_hi;
         REG_MS:      rd_mux = ms_count;
         REG_SCRATCH: rd_mux = scratch;
         REG_CAPS:    rd_mux = {VERSION, 8'd3, 8'd0};
         REG_CTRL:    rd_mux = '0;
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cyc_cnt  <= '0;
         presc    <= '0;
         ms_count <= '0;
      end else if (clr) begin
         cyc_cnt  <= '0;
         presc    <= '0;
         ms_count <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + 64'd1;
         if (presc == PRESC_MAX) begin
            presc    <= '0;
            ms_count <= ms_count + 32'd1;
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch <= SCRATCH_INIT;
      end else if (wr && (addr == REG_SCRATCH)) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.byteenable[i]) begin
               scratch[8*i +: 8] <= bus.writedata[8*i +: 8];
            end
         end
      end
   end

   // Reading CYC_LO latches the upper word so a following CYC_HI read
   // pairs with it, regardless of carries in between.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.readdata      <= '0;
         bus.readdatavalid <= 1'b0;
         cyc_snap_hi       <= '0;
      end else begin
         bus.readdatavalid <= rd;
         if (rd) begin
            bus.readdata <= rd_mux;
            if (addr == REG_CYC_LO) begin
               cyc_snap_hi <= cyc_cnt[63:32];
            end
         end
      end
   end

endmodule

// File: tb/tb_sysid_timer_regs.sv
// Directed bench for sysid_timer_regs, built with TICK_DIV=4 and HB_BIT=1.
module tb_sysid_timer_regs;
   localparam logic [31:0] ID_W   = 32'h59E6_1DEB;
   localparam logic [31:0] TS_W   = 32'h0;
   localparam logic [31:0] CAPS_W = 32'h0002_0300;

   logic clock;
   logic reset_n;
   logic heartbeat;
   int   tests;
   int   fails;
   logic [31:0] saved;

   sysid_timer_regs_if bus ();

   sysid_timer_regs #(
      .TICK_DIV (4),
      .HB_BIT   (1)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus),
      .heartbeat (heartbeat)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      bus.write      = 1'b0;
      bus.address    = '0;
      bus.writedata  = '0;
      bus.byteenable = '0;
   endtask

   task automatic rd_drive(input logic [2:0] a);
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.write      = 1'b0;
      bus.address    = a;
   endtask

   task automatic wr_drive(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.chipselect = 1'b1;
      bus.read       = 1'b0;
      bus.write      = 1'b1;
      bus.address    = a;
      bus.writedata  = d;
      bus.byteenable = be;
   endtask

   // Checks the response of the read issued at the previous negedge.
   task automatic chk_rd(input string tag, input logic [31:0] exp);
      chk({tag, "_valid"}, 32'(bus.readdatavalid), 32'd1);
      chk(tag, bus.readdata, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      reset_n = 1'b0;
      bus_idle();
      repeat (2) @(negedge clock);
      chk("rst_readdata", bus.readdata, 32'd0);
      chk("rst_rdv", 32'(bus.readdatavalid), 32'd0);
      chk("rst_heartbeat", 32'(heartbeat), 32'd0);

      // ms ticks every 4 edges; heartbeat = ms[1]
      reset_n = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         chk("heartbeat", 32'(heartbeat), 32'(((k / 4) >> 1) & 1));
      end
      rd_drive(3'd4);
      @(negedge clock);
      chk_rd("ms_after_40", 32'd10);

      // back-to-back fixed-word reads
      rd_drive(3'd0);
      @(negedge clock);
      chk_rd("id", ID_W);
      rd_drive(3'd1);
      @(negedge clock);
      chk_rd("timestamp", TS_W);
      rd_drive(3'd6);
      @(negedge clock);
      chk_rd("caps", CAPS_W);
      bus_idle();
      @(negedge clock);
      chk("idle_rdv", 32'(bus.readdatavalid), 32'd0);
      chk("idle_hold", bus.readdata, CAPS_W);

      // byte-lane scratch write, read next cycle
      wr_drive(3'd5, 32'hAABB_CCDD, 4'b0101);
      @(negedge clock);
      chk("write_no_rdv", 32'(bus.readdatavalid), 32'd0);
      rd_drive(3'd5);
      @(negedge clock);
      chk_rd("scratch_be", 32'h00BB_00DD);

      // read-only and CTRL behaviour
      wr_drive(3'd0, 32'hFFFF_FFFF, 4'hF);
      @(negedge clock);
      rd_drive(3'd0);
      @(negedge clock);
      chk_rd("id_ro", ID_W);
      rd_drive(3'd7);
      @(negedge clock);
      chk_rd("ctrl_reads0", 32'd0);
      bus_idle();

      // coherent 64-bit read across a carry
      @(negedge clock);
      force dut.cyc_cnt = 64'h0000_0001_FFFF_FFFE;
      rd_drive(3'd2);
      #1 release dut.cyc_cnt;
      @(negedge clock);
      chk_rd("cyc_lo_snap", 32'hFFFF_FFFE);
      bus_idle();
      @(negedge clock);
      rd_drive(3'd3);
      @(negedge clock);
      chk_rd("cyc_hi_snap", 32'h0000_0001);
      bus_idle();

      // 64-bit wrap
      @(negedge clock);
      force dut.cyc_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      rd_drive(3'd2);
      #1 release dut.cyc_cnt;
      @(negedge clock);
      chk_rd("wrap_lo0", 32'hFFFF_FFFF);
      rd_drive(3'd3);
      @(negedge clock);
      chk_rd("wrap_hi0", 32'hFFFF_FFFF);
      rd_drive(3'd2);
      @(negedge clock);
      chk_rd("wrap_lo1", 32'h0000_0001);
      rd_drive(3'd3);
      @(negedge clock);
      chk_rd("wrap_hi1", 32'h0000_0000);
      bus_idle();

      // CTRL clear after a long run
      repeat (1000) @(negedge clock);
      rd_drive(3'd2);
      @(negedge clock);
      saved = bus.readdata;
      chk("pre_clear_large", 32'(saved >= 32'd900), 32'd1);
      wr_drive(3'd7, 32'd1, 4'hF);
      @(negedge clock);
      rd_drive(3'd2);
      @(negedge clock);
      chk("post_clear_valid", 32'(bus.readdatavalid), 32'd1);
      chk("post_clear_lt10", 32'(bus.readdata < 32'd10), 32'd1);
      rd_drive(3'd4);
      @(negedge clock);
      chk_rd("post_clear_ms", 32'd0);

      // simultaneous read+write: read served, write dropped
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      bus.write      = 1'b1;
      bus.address    = 3'd5;
      bus.writedata  = 32'h1234_5678;
      bus.byteenable = 4'hF;
      @(negedge clock);
      chk_rd("rw_read", 32'h00BB_00DD);
      rd_drive(3'd5);
      @(negedge clock);
      chk_rd("rw_unchanged", 32'h00BB_00DD);
      bus_idle();

      // reset during a read response
      @(negedge clock);
      rd_drive(3'd0);
      @(posedge clock);
      #1;
      chk("pre_reset_rdv", 32'(bus.readdatavalid), 32'd1);
      bus_idle();
      #1 reset_n = 1'b0;
      #1;
      chk("reset_rdv_drop", 32'(bus.readdatavalid), 32'd0);
      chk("reset_readdata", bus.readdata, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         chk("no_pending_rdv", 32'(bus.readdatavalid), 32'd0);
      end
      rd_drive(3'd5);
      @(negedge clock);
      chk_rd("scratch_reset", 32'd0);
      bus_idle();
      @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
